fir_par_block: RTL and testbench

Parametrised serial-in, block-parallel-out FIR filter. It accepts one input sample per `in_valid` cycle and computes a TAPS-tap direct-form output for every accepted sample. Outputs are packed into a PAR-lane block, emitted with a one-cycle `out_valid` strobe. It sits between the sample source and the block-rate downstream stage (DWT/polyphase back end) and adds four things: run-time coefficient loading, input flow control, partial-block flush, and saturating output.

---
 rtl/fir_par_block.sv | 140 ++++++++++++++
 tb/tb_fir_par_block.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_par_block.sv
// Serial-in, block-parallel-out FIR: one sample per accepted cycle, TAPS-tap direct form,
// results packed PAR lanes wide with run-time coefficients, flush and saturating output.
module fir_par_block #(
  parameter int W_IN = 5,
  parameter int C_W  = 3,
  parameter int TAPS = 4,
  parameter int PAR  = 6,
  parameter int Y_W  = 12,
  parameter int SAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [W_IN-1:0]     x_in,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [C_W-1:0]      coef_data,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [PAR*Y_W-1:0]         y_par,
  output logic [$clog2(PAR+1)-1:0]   out_cnt,
  output logic                       sat_flag
);

  // Handshake: in_valid=1 means x_in is consumed on that rising edge (no input ready);
  // out_valid is a single-cycle strobe with no ready, so the consumer captures y_par/out_cnt then.

  localparam int AW    = $clog2(TAPS);
  localparam int CW    = $clog2(PAR);
  localparam int OW    = $clog2(PAR + 1);
  localparam int PW    = C_W + W_IN;
  localparam int SUM_W = W_IN + C_W + $clog2(TAPS);
  localparam int EXT_W = (SUM_W > Y_W) ? SUM_W : Y_W;

  localparam logic [AW:0]   TAPS_W   = (AW + 1)'(TAPS);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAR - 1);

  logic signed [W_IN-1:0] d_q [TAPS-1];
  logic signed [C_W-1:0]  c_q [TAPS];
  logic signed [Y_W-1:0]  l_q [PAR];
  logic [CW-1:0]          cnt_q;

  logic signed [W_IN-1:0]  samp [TAPS];
  logic signed [PW-1:0]    prod [TAPS];
  logic signed [EXT_W-1:0] sum_ext;
  logic [EXT_W-Y_W:0]      top_bits;
  logic                    ovf;
  logic signed [Y_W-1:0]   y_fit;

  logic                    accept_last;
  logic [OW-1:0]           pend_cnt;
  logic                    emit;
  logic [PAR*Y_W-1:0]      emit_vec;

  always_comb begin
    samp[0] = x_in;
    for (int i = 1; i < TAPS; i++) begin
      samp[i] = d_q[i-1];
    end
  end

  // Full-precision sum, widened enough that neither the tap sum nor the lane width can clip it.
  always_comb begin
    sum_ext = '0;
    for (int i = 0; i < TAPS; i++) begin
      prod[i] = PW'(c_q[i]) * PW'(samp[i]);
      sum_ext = sum_ext + EXT_W'(prod[i]);
    end
  end

  // Representable in Y_W bits exactly when every bit from Y_W-1 upward matches the sign.
  always_comb begin
    top_bits = sum_ext[EXT_W-1:Y_W-1];
    ovf      = !((&top_bits) || !(|top_bits));
    y_fit    = sum_ext[Y_W-1:0];
    if (ovf && (SAT != 0)) begin
      y_fit = sum_ext[EXT_W-1] ? {1'b1, {(Y_W-1){1'b0}}} : {1'b0, {(Y_W-1){1'b1}}};
    end
  end

  // The sample accepted this cycle counts as pending, so flush can emit it immediately.
  always_comb begin
    accept_last = in_valid && (cnt_q == LAST_IDX);
    pend_cnt    = OW'(cnt_q) + OW'(in_valid);
    emit        = accept_last || (flush && (pend_cnt != '0));
  end

  always_comb begin
    emit_vec = '0;
    for (int k = 0; k < PAR; k++) begin
      if (CW'(k) < cnt_q) begin
        emit_vec[k*Y_W +: Y_W] = l_q[k];
      end else if ((CW'(k) == cnt_q) && in_valid) begin
        emit_vec[k*Y_W +: Y_W] = y_fit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS - 1; i++) d_q[i] <= '0;
      for (int i = 0; i < TAPS; i++)     c_q[i] <= '0;
      for (int k = 0; k < PAR; k++)      l_q[k] <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      y_par     <= '0;
      out_cnt   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (in_valid) begin
        l_q[cnt_q] <= y_fit;
        d_q[0]     <= x_in;
        for (int i = 1; i < TAPS - 1; i++) begin
          d_q[i] <= d_q[i-1];
        end
        if (ovf) begin
          sat_flag <= 1'b1;
        end
      end

      // The sample accepted this cycle already used the old coefficient above.
      if (coef_we && ({1'b0, coef_addr} < TAPS_W)) begin
        c_q[coef_addr] <= coef_data;
      end

      if (emit) begin
        cnt_q <= '0;
      end else if (in_valid) begin
        cnt_q <= cnt_q + 1'b1;
      end

      out_valid <= emit;
      if (emit) begin
        y_par   <= emit_vec;
        out_cnt <= pend_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fir_par_block.sv
// Bench for fir_par_block: default instance plus two narrow-output instances (saturate / wrap)
// sharing the same stimulus, checked against a queue-based arithmetic model.
module tb_fir_par_block;

  localparam int W_IN = 5;
  localparam int C_W  = 3;
  localparam int TAPS = 4;
  localparam int PAR  = 6;
  localparam int Y_W  = 12;
  localparam int Y_S  = 6;
  localparam int AW   = $clog2(TAPS);
  localparam int OW   = $clog2(PAR + 1);
  localparam int BW   = PAR * Y_W;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            coef_we = 1'b0;
  logic [W_IN-1:0] x_in = '0;
  logic [AW-1:0]   coef_addr = '0;
  logic [C_W-1:0]  coef_data = '0;

  logic             out_valid, sat_flag;
  logic [BW-1:0]    y_par;
  logic [OW-1:0]    out_cnt;
  logic             s_valid, s_flag, w_valid, w_flag;
  logic [PAR*Y_S-1:0] s_y, w_y;
  logic [OW-1:0]    s_cnt, w_cnt;

  fir_par_block #(.W_IN(W_IN), .C_W(C_W), .TAPS(TAPS), .PAR(PAR), .Y_W(Y_W), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush),
    .out_valid(out_valid), .y_par(y_par), .out_cnt(out_cnt), .sat_flag(sat_flag));

  fir_par_block #(.W_IN(W_IN), .C_W(C_W), .TAPS(TAPS), .PAR(PAR), .Y_W(Y_S), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush),
    .out_valid(s_valid), .y_par(s_y), .out_cnt(s_cnt), .sat_flag(s_flag));

  fir_par_block #(.W_IN(W_IN), .C_W(C_W), .TAPS(TAPS), .PAR(PAR), .Y_W(Y_S), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush),
    .out_valid(w_valid), .y_par(w_y), .out_cnt(w_cnt), .sat_flag(w_flag));

  always #5 clk = ~clk;

  // Model state: coefficients, sample history (newest first) and pending full-precision lanes.
  int  mc[TAPS];
  int  mh[TAPS];
  int  pend[$];
  int  last_raw[$];
  bit  mflag[3];
  int  vyw[3] = '{Y_W, Y_S, Y_S};

  logic [BW-1:0] exp_q[$];
  int            exp_cnt_q[$];
  int            exp_t_q[$];
  logic [BW-1:0] obs_q[$];
  int            obs_cnt_q[$];
  int            obs_t_q[$];
  logic [BW-1:0] s_last, w_last;

  int cyc;
  int n_total;
  int n_pass;

  function automatic int fit(input int raw, input int yw, input bit sat);
    int hi;
    int lo;
    int v;
    hi = (1 << (yw - 1)) - 1;
    lo = -(1 << (yw - 1));
    if (raw >= lo && raw <= hi) return raw;
    if (sat) return (raw > hi) ? hi : lo;
    v = raw & ((1 << yw) - 1);
    if (v > hi) v = v - (1 << yw);
    return v;
  endfunction

  function automatic logic [BW-1:0] pack_blk(input int raws[$], input int yw, input bit sat);
    logic [BW-1:0] b;
    int v;
    b = '0;
    for (int k = 0; k < raws.size(); k++) begin
      v = fit(raws[k], yw, sat);
      for (int bb = 0; bb < yw; bb++) b[k*yw + bb] = v[bb];
    end
    return b;
  endfunction

  task automatic model_edge(input bit iv, input int x, input bit fl, input bit we,
                            input int addr, input int data);
    int raw;
    if (iv) begin
      raw = mc[0] * x;
      for (int i = 1; i < TAPS; i++) raw += mc[i] * mh[i-1];
      pend.push_back(raw);
      for (int j = 0; j < 3; j++) if (fit(raw, vyw[j], 1'b1) != raw) mflag[j] = 1'b1;
    end
    if (we && addr < TAPS) mc[addr] = data;
    if (iv) begin
      for (int i = TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = x;
    end
    if (pend.size() == PAR || (fl && pend.size() > 0)) begin
      exp_q.push_back(pack_blk(pend, Y_W, 1'b1));
      exp_cnt_q.push_back(pend.size());
      exp_t_q.push_back(cyc);
      last_raw = pend;
      pend.delete();
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mc[i] = 0;
      mh[i] = 0;
    end
    pend.delete();
    for (int j = 0; j < 3; j++) mflag[j] = 1'b0;
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_cnt_q.delete(); exp_t_q.delete();
    obs_q.delete(); obs_cnt_q.delete(); obs_t_q.delete();
  endtask

  task automatic step(input bit iv, input int x, input bit fl, input bit we,
                      input int addr, input int data);
    in_valid  = iv;
    x_in      = x[W_IN-1:0];
    flush     = fl;
    coef_we   = we;
    coef_addr = addr[AW-1:0];
    coef_data = data[C_W-1:0];
    @(posedge clk);
    cyc++;
    model_edge(iv, x, fl, we, addr, data);
    #1;
    if (out_valid) begin
      obs_q.push_back(y_par);
      obs_cnt_q.push_back(int'(out_cnt));
      obs_t_q.push_back(cyc);
    end
    if (s_valid) s_last = {{(BW-PAR*Y_S){1'b0}}, s_y};
    if (w_valid) w_last = {{(BW-PAR*Y_S){1'b0}}, w_y};
    in_valid = 1'b0;
    flush    = 1'b0;
    coef_we  = 1'b0;
  endtask

  // Leaves rst asserted so the caller can observe outputs while reset is held.
  task automatic apply_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    coef_we  = 1'b0;
    @(posedge clk);
    cyc++;
    model_reset();
    #1;
  endtask

  task automatic load_coefs(input int c[TAPS]);
    for (int i = 0; i < TAPS; i++) step(1'b0, 0, 1'b0, 1'b1, i, c[i]);
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({out_valid, y_par, out_cnt, sat_flag} !== '0)
      $display("FAIL reset_main: got v=%0b y=%0h cnt=%0d sat=%0b expected all 0", out_valid, y_par, out_cnt, sat_flag);
    else n_pass++;
    n_total++;
    if ({s_valid, s_y, s_cnt, s_flag, w_valid, w_y, w_cnt, w_flag} !== '0)
      $display("FAIL reset_narrow: got s=%0h w=%0h expected 0", s_y, w_y);
    else n_pass++;
    rst = 1'b0;
    step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    n_total++;
    if ({out_valid, y_par, out_cnt, sat_flag} !== '0)
      $display("FAIL reset_idle_flush: got v=%0b cnt=%0d expected no emit", out_valid, out_cnt);
    else n_pass++;
  endtask

  task automatic test_impulse();
    int imp[$] = '{-1, -1, -2, 3, 0, 0};
    int t_last;
    clear_sb();
    load_coefs('{-1, -1, -2, 3});
    for (int n = 0; n < PAR; n++) step(1'b1, (n == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0);
    t_last = cyc;
    n_total++;
    if (obs_q.size() != 1) $display("FAIL impulse_count: got %0d expected 1", obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0) begin
      n_total++;
      if (obs_q[0] !== pack_blk(imp, Y_W, 1'b1) || obs_cnt_q[0] != PAR || obs_t_q[0] != t_last)
        $display("FAIL impulse_blk: got %0h cnt=%0d @%0d expected %0h cnt=%0d @%0d",
                 obs_q[0], obs_cnt_q[0], obs_t_q[0], pack_blk(imp, Y_W, 1'b1), PAR, t_last);
      else n_pass++;
    end
    n_total++;
    if (sat_flag !== 1'b0) $display("FAIL impulse_sat: got %0b expected 0", sat_flag);
    else n_pass++;
  endtask

  task automatic test_stall();
    int imp[$] = '{-1, -1, -2, 3, 0, 0};
    int t_last;
    clear_sb();
    t_last = 0;
    for (int n = 0; n < 2 * PAR; n++) begin
      step((n % 2) == 0, (n == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0);
      if (n == 2 * PAR - 2) t_last = cyc;
    end
    step(1'b0, 0, 1'b0, 1'b0, 0, 0);
    n_total++;
    if (obs_q.size() != 1 || obs_t_q.size() != 1)
      $display("FAIL stall_count: got %0d expected 1", obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0) begin
      n_total++;
      if (obs_q[0] !== pack_blk(imp, Y_W, 1'b1) || obs_t_q[0] != t_last)
        $display("FAIL stall_blk: got %0h @%0d expected %0h @%0d", obs_q[0], obs_t_q[0],
                 pack_blk(imp, Y_W, 1'b1), t_last);
      else n_pass++;
    end
    n_total++;
    if (out_valid !== 1'b0 || y_par !== pack_blk(imp, Y_W, 1'b1) || out_cnt !== OW'(PAR))
      $display("FAIL stall_hold: got v=%0b y=%0h cnt=%0d expected held block", out_valid, y_par, out_cnt);
    else n_pass++;
  endtask

  task automatic test_flush();
    int part[$] = '{-2, -4};
    // Continuation from history 2,2: -1*2-2*2, -2*2+3*2, 3*2.
    int cont[$] = '{-6, 2, 6, 0, 0, 0};
    clear_sb();
    step(1'b1, 2, 1'b0, 1'b0, 0, 0);
    step(1'b1, 2, 1'b0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    for (int n = 0; n < PAR; n++) step(1'b1, 0, 1'b0, 1'b0, 0, 0);
    n_total++;
    if (obs_q.size() != 2) $display("FAIL flush_count: got %0d expected 2", obs_q.size());
    else n_pass++;
    if (obs_q.size() == 2) begin
      n_total++;
      if (obs_q[0] !== pack_blk(part, Y_W, 1'b1) || obs_cnt_q[0] != 2)
        $display("FAIL flush_partial: got %0h cnt=%0d expected %0h cnt=2", obs_q[0], obs_cnt_q[0],
                 pack_blk(part, Y_W, 1'b1));
      else n_pass++;
      n_total++;
      if (obs_q[1] !== pack_blk(cont, Y_W, 1'b1) || obs_cnt_q[1] != PAR)
        $display("FAIL flush_cont: got %0h cnt=%0d expected %0h cnt=%0d", obs_q[1], obs_cnt_q[1],
                 pack_blk(cont, Y_W, 1'b1), PAR);
      else n_pass++;
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_total++;
      if (obs_q[k] !== exp_q[k] || obs_t_q[k] != exp_t_q[k])
        $display("FAIL flush_model%0d: got %0h @%0d expected %0h @%0d", k, obs_q[k], obs_t_q[k], exp_q[k], exp_t_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_flush_edge();
    clear_sb();
    step(1'b1, 3, 1'b1, 1'b0, 0, 0);
    for (int n = 0; n < PAR; n++) step(1'b1, $urandom_range(0, 31) - 16, n == PAR - 1, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    n_total++;
    if (obs_q.size() != 2 || obs_q.size() != exp_q.size())
      $display("FAIL flush_edge_count: got %0d expected 2", obs_q.size());
    else n_pass++;
    if (obs_cnt_q.size() == 2) begin
      n_total++;
      if (obs_cnt_q[0] != 1 || obs_cnt_q[1] != PAR)
        $display("FAIL flush_edge_cnt: got %0d,%0d expected 1,%0d", obs_cnt_q[0], obs_cnt_q[1], PAR);
      else n_pass++;
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_total++;
      if (obs_q[k] !== exp_q[k] || obs_t_q[k] != exp_t_q[k])
        $display("FAIL flush_edge_blk%0d: got %0h @%0d expected %0h @%0d", k, obs_q[k], obs_t_q[k], exp_q[k], exp_t_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_coef_collision();
    int want[$] = '{5, 10};
    clear_sb();
    load_coefs('{1, 0, 0, 0});
    step(1'b1, 5, 1'b0, 1'b1, 0, 2);
    step(1'b1, 5, 1'b0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    n_total++;
    if (obs_q.size() != 1) $display("FAIL coef_count: got %0d expected 1", obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0) begin
      n_total++;
      if (obs_q[0] !== pack_blk(want, Y_W, 1'b1) || obs_cnt_q[0] != 2)
        $display("FAIL coef_blk: got %0h cnt=%0d expected %0h cnt=2", obs_q[0], obs_cnt_q[0], pack_blk(want, Y_W, 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    load_coefs('{$urandom_range(0, 7) - 4, $urandom_range(0, 7) - 4,
                 $urandom_range(0, 7) - 4, $urandom_range(0, 7) - 4});
    for (int n = 0; n < 3 * PAR; n++) step(1'b1, $urandom_range(0, 31) - 16, 1'b0, 1'b0, 0, 0);
    n_total++;
    if (obs_q.size() != 3 || exp_q.size() != 3)
      $display("FAIL b2b_count: got %0d expected 3", obs_q.size());
    else n_pass++;
    for (int k = 1; k < obs_t_q.size(); k++) begin
      n_total++;
      if (obs_t_q[k] - obs_t_q[k-1] != PAR)
        $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, obs_t_q[k] - obs_t_q[k-1], PAR);
      else n_pass++;
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_total++;
      if (obs_q[k] !== exp_q[k] || obs_cnt_q[k] != exp_cnt_q[k] || obs_t_q[k] != exp_t_q[k])
        $display("FAIL b2b_blk%0d: got %0h/%0d@%0d expected %0h/%0d@%0d", k, obs_q[k], obs_cnt_q[k],
                 obs_t_q[k], exp_q[k], exp_cnt_q[k], exp_t_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    clear_sb();
    for (int n = 0; n < 120; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) - 16, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, TAPS - 1), $urandom_range(0, 7) - 4);
    end
    step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    n_total++;
    if (obs_q.size() != exp_q.size() || exp_q.size() == 0)
      $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_total++;
      if (obs_q[k] !== exp_q[k] || obs_cnt_q[k] != exp_cnt_q[k] || obs_t_q[k] != exp_t_q[k])
        $display("FAIL random_blk%0d: got %0h/%0d@%0d expected %0h/%0d@%0d", k, obs_q[k], obs_cnt_q[k],
                 obs_t_q[k], exp_q[k], exp_cnt_q[k], exp_t_q[k]);
      else n_pass++;
    end
    n_total++;
    if (sat_flag !== mflag[0]) $display("FAIL random_sat: got %0b expected %0b", sat_flag, mflag[0]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int s31[$] = '{31, 31, 31, 31, 31, 31};
    apply_reset();
    rst = 1'b0;
    clear_sb();
    load_coefs('{-4, -4, -4, -4});
    for (int n = 0; n < PAR; n++) step(1'b1, -16, 1'b0, 1'b0, 0, 0);
    n_total++;
    if (s_last !== pack_blk(s31, Y_S, 1'b1) || s_last !== pack_blk(last_raw, Y_S, 1'b1))
      $display("FAIL sat_lanes: got %0h expected %0h", s_last, pack_blk(s31, Y_S, 1'b1));
    else n_pass++;
    n_total++;
    if (w_last !== '0 || w_last !== pack_blk(last_raw, Y_S, 1'b0))
      $display("FAIL wrap_lanes: got %0h expected 0", w_last);
    else n_pass++;
    n_total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      $display("FAIL sat_main_blk: got %0h expected %0h", y_par, pack_blk(last_raw, Y_W, 1'b1));
    else n_pass++;
    n_total++;
    if (s_flag !== 1'b1 || w_flag !== 1'b1 || sat_flag !== 1'b0)
      $display("FAIL sat_flags: got s=%0b w=%0b main=%0b expected 1,1,0", s_flag, w_flag, sat_flag);
    else n_pass++;
    load_coefs('{1, 0, 0, 0});
    for (int n = 0; n < 3; n++) step(1'b1, 1, 1'b0, 1'b0, 0, 0);
    n_total++;
    if (s_flag !== 1'b1 || w_flag !== 1'b1 || s_flag !== mflag[1])
      $display("FAIL sat_sticky: got s=%0b w=%0b expected 1,1", s_flag, w_flag);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ones[$] = '{1, 1, 1, 1, 1, 1};
    int quiet_bad;
    apply_reset();
    rst = 1'b0;
    load_coefs('{1, 0, 0, 0});
    clear_sb();
    for (int n = 0; n < 3; n++) step(1'b1, $urandom_range(0, 31) - 16, 1'b0, 1'b0, 0, 0);
    n_total++;
    if (obs_q.size() != 0) $display("FAIL rmid_early: got %0d emits expected 0", obs_q.size());
    else n_pass++;
    apply_reset();
    n_total++;
    if ({out_valid, y_par, out_cnt, sat_flag} !== '0)
      $display("FAIL rmid_during: got v=%0b y=%0h cnt=%0d expected 0", out_valid, y_par, out_cnt);
    else n_pass++;
    rst = 1'b0;
    quiet_bad = 0;
    load_coefs('{1, 0, 0, 0});
    for (int n = 0; n < PAR; n++) begin
      step(1'b1, 1, 1'b0, 1'b0, 0, 0);
      if (n < PAR - 1 && {out_valid, y_par, out_cnt} !== '0) quiet_bad++;
    end
    n_total++;
    if (quiet_bad != 0) $display("FAIL rmid_quiet: got %0d nonzero cycles expected 0", quiet_bad);
    else n_pass++;
    n_total++;
    if (obs_q.size() != 1 || y_par !== pack_blk(ones, Y_W, 1'b1) || out_cnt !== OW'(PAR))
      $display("FAIL rmid_blk: got %0h cnt=%0d expected %0h cnt=%0d", y_par, out_cnt, pack_blk(ones, Y_W, 1'b1), PAR);
    else n_pass++;
  endtask

  initial begin
    cyc     = 0;
    n_total = 0;
    n_pass  = 0;
    s_last  = '0;
    w_last  = '0;
    model_reset();
    test_reset();
    test_impulse();
    test_stall();
    test_flush();
    test_flush_edge();
    test_coef_collision();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
